instr_ram_dp: RTL and testbench

//  Parametrised dual-port instruction memory for the RV32 core. Port A is the fetch port:
//   req/ready handshake, 1-cycle read latency, stall hold. Port B is the debug/loader port:

---
 rtl/instr_ram_pkg.sv | 17 +
 rtl/instr_ram_bank.sv | 81 ++++++++
 rtl/instr_ram_dp.sv | 106 ++++++++++
 tb/tb_instr_ram_dp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_ram_pkg.sv
// Shared types and helpers for the dual-port instruction RAM.
package instr_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // RV32 canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Even parity: the stored bit makes the 9-bit group have an even number of ones
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/instr_ram_bank.sv
// True dual-port storage array with byte enables, read-first on both ports.
// Port A reads only when enabled, so its output register holds between fetches.
// Port B reads every cycle and writes the enabled bytes on the same edge.
// With INSTR_RAM_PARITY_EN defined, a parity plane (one bit per byte) is kept
// in step with port B writes and checked on every port A read.
module instr_ram_bank
  import instr_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic [ADDR_W-1:0]     a_addr,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_perr,
  input  logic [DATA_W/8-1:0]   b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata
);

  localparam int NBYTE = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_p1;
  logic [DATA_W-1:0] b_rdata_p1;

  // Port B byte-granular write into the data array
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTE; i++) begin
      if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
    end
  end

  // Read registers: nonblocking reads return the pre-write word on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
    end else begin
      if (a_en) a_rdata_p1 <= mem[a_addr];
      b_rdata_p1 <= mem[b_addr];
    end
  end

  assign a_rdata = a_rdata_p1;
  assign b_rdata = b_rdata_p1;

`ifdef INSTR_RAM_PARITY_EN
  logic [NBYTE-1:0] par_mem [DEPTH];
  logic             a_perr_p1;

  function automatic logic [NBYTE-1:0] word_parity(input logic [DATA_W-1:0] w);
    logic [NBYTE-1:0] p;
    p = '0;
    for (int i = 0; i < NBYTE; i++) p[i] = byte_parity(w[i*8 +: 8]);
    return p;
  endfunction

  // Parity plane follows every byte written through port B
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTE; i++) begin
      if (b_we[i]) par_mem[b_addr][i] <= byte_parity(b_wdata[i*8 +: 8]);
    end
  end

  // Parity check registered alongside the port A data, same hold behaviour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_perr_p1 <= 1'b0;
    else if (a_en) a_perr_p1 <= |(par_mem[a_addr] ^ word_parity(mem[a_addr]));
  end

  assign a_perr = a_perr_p1;
`else
  assign a_perr = 1'b0;
`endif

endmodule

// File: rtl/instr_ram_dp.sv
// Dual-port instruction memory for the RV32 core.
// Port A: fetch with req/ready handshake, 1-cycle latency, output hold on stall.
// Port B: debug/loader byte-enable write and read-first read.
// A clear FSM fills the array with CLR_WORD after reset (CLR_ON_RST) or on clr_req;
// while it runs it owns port B and fetches are refused.
// Optional parity plane: define INSTR_RAM_PARITY_EN.
module instr_ram_dp
  import instr_ram_pkg::*;
#(
  parameter int              ADDR_W     = 10,
  parameter int              DATA_W     = 32,
  parameter logic [DATA_W-1:0] CLR_WORD = DATA_W'(NOP_WORD),
  parameter bit              CLR_ON_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  input  logic                if_stall,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_perr,
  input  logic [DATA_W/8-1:0] dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_ready,
  input  logic                clr_req,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e          state;
  logic [ADDR_W-1:0]   cnt;
  logic                boot;
  logic                fetch_acc;
  logic                vld_p1;
  logic [DATA_W/8-1:0] b_we;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_wdata;

  assign busy      = (state == CLEAR);
  assign dbg_ready = !busy;
  assign if_ready  = !busy && !if_stall;
  assign fetch_acc = if_req && if_ready;

  // Clear FSM; boot marks the first edge after reset for the automatic clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      boot  <= 1'b1;
    end else begin
      boot <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req || (CLR_ON_RST && boot)) state <= CLEAR;
        end
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch valid: set on accept, dropped when idle, frozen while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else if (!if_stall) vld_p1 <= fetch_acc;
  end

  assign if_rvalid = vld_p1;

  // Port B owner: clear FSM while busy, debug port otherwise (dbg_we ignored when busy)
  always_comb begin
    b_we    = dbg_we;
    b_addr  = dbg_addr;
    b_wdata = dbg_wdata;
    if (busy) begin
      b_we    = '1;
      b_addr  = cnt;
      b_wdata = CLR_WORD;
    end
  end

  instr_ram_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .a_en    (fetch_acc),
    .a_addr  (if_addr),
    .a_rdata (if_rdata),
    .a_perr  (if_perr),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_instr_ram_dp.sv
// Scoreboard bench for instr_ram_dp: the driver pushes expected fetch/debug results
// from a word-array model; a negedge monitor pops and compares as results appear.
module tb_instr_ram_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic        if_ready;
  logic        if_stall = 1'b0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_perr;
  logic [3:0]  dbg_we = '0;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_ready;
  logic        clr_req = 1'b0;
  logic        busy;

  instr_ram_dp dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_perr(if_perr),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        p;
  } exp_t;

  logic [31:0] model_mem [1024];
  exp_t        exp_q [$];
  logic [31:0] dbg_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        perr_inj = 1'b0;

  logic cyc_acc = 1'b0, cyc_stall = 1'b0, cyc_dbg = 1'b0;
  logic m_acc = 1'b0, m_stall = 1'b0, m_dbg = 1'b0;

  logic        exp_v = 1'b0;
  logic [31:0] exp_d = '0;
  logic        exp_p = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle intent captured at the edge the DUT samples it
  always @(posedge clk) begin
    m_acc   <= cyc_acc;
    m_stall <= cyc_stall;
    m_dbg   <= cyc_dbg;
  end

  // Monitor: derives expected outputs from the scoreboard queues
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_v = 1'b0; exp_d = '0; exp_p = 1'b0;
      exp_q.delete();
      dbg_q.delete();
    end else begin
      if (m_acc) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fetch_underflow: no expected entry queued");
        end else begin
          e = exp_q.pop_front();
          exp_v = 1'b1; exp_d = e.d; exp_p = e.p;
        end
      end else if (!m_stall) begin
        exp_v = 1'b0;
      end
      chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_v});
      if (exp_v) chk("if_rdata", if_rdata, exp_d);
      chk("if_perr", {31'b0, if_perr}, {31'b0, exp_p});
      if (m_dbg) begin
        if (dbg_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dbg_underflow: no expected entry queued");
        end else begin
          chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; bsy marks cycles the bench knows the clear is running
  task automatic cyc(input logic req, input logic [9:0] a, input logic st,
                     input logic [3:0] we, input logic [9:0] da, input logic [31:0] wd,
                     input logic dchk, input logic bsy);
    exp_t e;
    if_req = req; if_addr = a; if_stall = st;
    dbg_we = we; dbg_addr = da; dbg_wdata = wd;
    cyc_acc   = req && !st && !bsy;
    cyc_stall = st;
    cyc_dbg   = dchk && !bsy;
    if (cyc_acc) begin
      e.d = model_mem[a];
      e.p = perr_inj && (a == 10'd3);
      exp_q.push_back(e);
    end
    if (cyc_dbg) dbg_q.push_back(model_mem[da]);
    if (!bsy) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) model_mem[da][i*8 +: 8] = wd[i*8 +: 8];
    end
    @(posedge clk);
    #2;
    clr_req = 1'b0;
  endtask

  task automatic idle(input int n, input logic bsy);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, bsy);
  endtask

  task automatic fetch(input logic [9:0] a);
    cyc(1'b1, a, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 1'b0);
  endtask

  // Runs a clear to completion, counting busy cycles; optional side stimulus mid-clear
  task automatic run_clear(output int n, input int pulse_at, input int dbgw_at, input int req_at);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      if (k == pulse_at) clr_req = 1'b1;
      if (k == req_at)
        cyc(1'b1, 10'd20, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 1'b1);
      else if (k == dbgw_at)
        cyc(1'b0, 10'd0, 1'b0, 4'hF, 10'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
      else
        idle(1, 1'b1);
      if (k == 5) begin
        chk("if_ready_busy", {31'b0, if_ready}, 32'd0);
        chk("dbg_ready_busy", {31'b0, dbg_ready}, 32'd0);
      end
      if (busy) n++;
      else if (n > 0) break;
    end
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0000_0013;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    // Reset values
    chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
    chk("rst_dbg_ready", {31'b0, dbg_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_if_perr", {31'b0, if_perr}, 32'd0);
    rst = 1'b0;

    // Automatic clear after reset, with a refused fetch and an ignored dbg write
    run_clear(n, -1, 1000, 10);
    chk("clear_cycles", n, 32'd1024);
    fetch(10'd0); fetch(10'd1023); fetch(10'd7);
    idle(2, 1'b0);

    // Full-word debug write then fetch
    cyc(1'b0, 10'd0, 1'b0, 4'hF, 10'd5, 32'h0070_4713, 1'b0, 1'b0);
    fetch(10'd5);
    chk("fetch5_const", if_rdata, 32'h0070_4713);
    idle(1, 1'b0);

    // Single-byte write, read-first return, then readback
    cyc(1'b0, 10'd0, 1'b0, 4'b0010, 10'd5, 32'hAABB_CCDD, 1'b1, 1'b0);
    cyc(1'b0, 10'd0, 1'b0, 4'b0000, 10'd5, 32'h0, 1'b1, 1'b0);
    chk("byte_we_const", dbg_rdata, 32'h0070_CC13);

    // Fetch then stall three cycles with a pending request to addr 6
    cyc(1'b0, 10'd0, 1'b0, 4'hF, 10'd6, 32'h0BAD_0006, 1'b0, 1'b0);
    fetch(10'd5);
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'd6, 1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 1'b0);
    chk("stall_hold_const", if_rdata, 32'h0070_CC13);
    fetch(10'd6);
    chk("after_stall_const", if_rdata, 32'h0BAD_0006);
    idle(2, 1'b0);

    // Same-address collision: port A sees the old word, then the new one
    cyc(1'b0, 10'd0, 1'b0, 4'hF, 10'd9, 32'hCAFE_F00D, 1'b0, 1'b0);
    cyc(1'b1, 10'd9, 1'b0, 4'hF, 10'd9, 32'h1234_5678, 1'b1, 1'b0);
    chk("collision_old", if_rdata, 32'hCAFE_F00D);
    fetch(10'd9);
    chk("collision_new", if_rdata, 32'h1234_5678);
    idle(2, 1'b0);

    // Randomized traffic on a small address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      logic [3:0] we;
      we = ($urandom_range(2, 0) == 0) ? 4'h0 : 4'($urandom);
      cyc($urandom_range(9, 0) < 6, 10'($urandom_range(15, 0)), $urandom_range(3, 0) == 0,
          we, 10'($urandom_range(15, 0)), $urandom, 1'b1, 1'b0);
    end
    idle(2, 1'b0);

    // Requested clear interrupted by reset, then the automatic re-clear
    clr_req = 1'b1;
    idle(100, 1'b1);
    rst = 1'b1;
    #1;
    chk("midclr_rst_busy", {31'b0, busy}, 32'd0);
    chk("midclr_rst_ready", {31'b0, if_ready}, 32'd1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    run_clear(n, 500, -1, -1);
    chk("reclear_cycles", n, 32'd1024);
    fetch(10'd0); fetch(10'd5); fetch(10'd9); fetch(10'd1023);
    idle(2, 1'b0);

`ifdef INSTR_RAM_PARITY_EN
    dut.u_bank.par_mem[3][0] = ~dut.u_bank.par_mem[3][0];
    perr_inj = 1'b1;
    fetch(10'd3);
    idle(1, 1'b0);
    perr_inj = 1'b0;
    fetch(10'd4);
    idle(2, 1'b0);
`endif

    idle(2, 1'b0);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
